raw_hazard_scoreboard: RTL and testbench

- Read-after-write hazard unit for the non-forwarding pipeline. It sits in the decode stage, beside the register file read ports.
- Holds a shadow copy of the destination registers of in-flight instructions (EX, MEM, WB).
- Stalls the instruction in ID while any source register it uses has a pending write.
- Checks that the writes reaching the register file match the shadow pipeline. It also keeps a stall-cycle performance counter.

---
 rtl/raw_hazard_scoreboard_if.sv | 47 ++++
 rtl/raw_hazard_scoreboard.sv | 111 +++++++++++
 tb/tb_raw_hazard_scoreboard.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/raw_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : raw_hazard_scoreboard_if
// Description : Decode-stage, writeback and status signals of the RAW hazard
//               scoreboard.
//               The pipeline controller side uses modport master.
//               The scoreboard side uses modport slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface raw_hazard_scoreboard_if #(
    parameter int CNT_W = 32
);
    logic             id_valid_i;
    logic [4:0]       id_rs1_addr_i;
    logic             id_rs1_used_i;
    logic [4:0]       id_rs2_addr_i;
    logic             id_rs2_used_i;
    logic [4:0]       id_rd_addr_i;
    logic             id_rd_wren_i;
    logic             hold_i;
    logic             flush_i;
    logic [4:0]       wb_rd_addr_i;
    logic             wb_rd_wren_i;
    logic             stall_o;
    logic             stall_rs1_o;
    logic             stall_rs2_o;
    logic [3:0]       inflight_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic             wb_mismatch_o;

    modport master (
        output id_valid_i, id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i,
               id_rs2_used_i, id_rd_addr_i, id_rd_wren_i, hold_i, flush_i,
               wb_rd_addr_i, wb_rd_wren_i,
        input  stall_o, stall_rs1_o, stall_rs2_o, inflight_o,
               stall_cycles_o, wb_mismatch_o
    );

    modport slave (
        input  id_valid_i, id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i,
               id_rs2_used_i, id_rd_addr_i, id_rd_wren_i, hold_i, flush_i,
               wb_rd_addr_i, wb_rd_wren_i,
        output stall_o, stall_rs1_o, stall_rs2_o, inflight_o,
               stall_cycles_o, wb_mismatch_o
    );
endinterface
`default_nettype wire

// File: rtl/raw_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : raw_hazard_scoreboard
// Description : Read-after-write hazard unit for a non-forwarding pipeline.
//               It keeps a shadow shift register of the in-flight
//               destinations (EX..WB) and stalls ID on any pending source.
//               It also checks register-file writes against that shadow and
//               counts stall cycles with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module raw_hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 32
) (
    input  wire logic               clk_i,
    input  wire logic               rst_ni,
    raw_hazard_scoreboard_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Slot 0 is EX, slot DEPTH-1 is WB.
    // A slot is valid only when its rd is not x0.
    logic [DEPTH-1:0]      slot_valid;
    logic [DEPTH-1:0][4:0] slot_rd;

    logic             hit_rs1;
    logic             hit_rs2;
    logic             stall_rs1;
    logic             stall_rs2;
    logic             stall;
    logic             issue;
    logic             wb_bad;
    logic [3:0]       valid_count;
    logic [CNT_W-1:0] stall_cnt;
    logic             mismatch;

    // Compare each source address against every pending destination.
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_valid[k] && (slot_rd[k] == bus.id_rs1_addr_i)) hit_rs1 = 1'b1;
            if (slot_valid[k] && (slot_rd[k] == bus.id_rs2_addr_i)) hit_rs2 = 1'b1;
        end
    end

    // The WB slot still counts as a hazard: the register file has no write-through.
    assign stall_rs1 = bus.id_valid_i & bus.id_rs1_used_i & (bus.id_rs1_addr_i != 5'd0) & hit_rs1;
    assign stall_rs2 = bus.id_valid_i & bus.id_rs2_used_i & (bus.id_rs2_addr_i != 5'd0) & hit_rs2;
    assign stall     = stall_rs1 | stall_rs2;

    // A flush or a stall turns the EX entry into a bubble. Writes to x0 are never tracked.
    assign issue = bus.id_valid_i & bus.id_rd_wren_i & (bus.id_rd_addr_i != 5'd0)
                 & ~stall & ~bus.flush_i;

    // Flag a write that was not expected, and an expected write that did not arrive or went to the wrong register.
    assign wb_bad = slot_valid[DEPTH-1]
                  ? (~bus.wb_rd_wren_i | (bus.wb_rd_addr_i != slot_rd[DEPTH-1]))
                  : (bus.wb_rd_wren_i & (bus.wb_rd_addr_i != 5'd0));

    // Population count of the valid slots.
    always_comb begin
        valid_count = 4'd0;
        for (int k = 0; k < DEPTH; k++) begin
            valid_count = valid_count + {3'd0, slot_valid[k]};
        end
    end

    // Advance the shadow pipeline unless the whole pipeline is frozen.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid <= '0;
            slot_rd    <= '0;
        end else if (!bus.hold_i) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_rd[k]    <= slot_rd[k-1];
            end
            slot_valid[0] <= issue;
            slot_rd[0]    <= issue ? bus.id_rd_addr_i : 5'd0;
        end
    end

    // Count unfrozen stall cycles and saturate at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
        end else if (!bus.hold_i && stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // Sticky writeback consistency flag; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mismatch <= 1'b0;
        end else if (!bus.hold_i && wb_bad) begin
            mismatch <= 1'b1;
        end
    end

    assign bus.stall_rs1_o    = stall_rs1;
    assign bus.stall_rs2_o    = stall_rs2;
    assign bus.stall_o        = stall;
    assign bus.inflight_o     = valid_count;
    assign bus.stall_cycles_o = stall_cnt;
    assign bus.wb_mismatch_o  = mismatch;

endmodule
`default_nettype wire

// File: tb/tb_raw_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_raw_hazard_scoreboard
// Description : Self-checking bench for raw_hazard_scoreboard.
//               It runs directed scenarios and then randomized traffic.
//               A list-of-pending-destinations model supplies every expected value.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_raw_hazard_scoreboard;
    localparam int DEPTH = 3;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    raw_hazard_scoreboard_if #(.CNT_W(CNT_W)) bus();

    raw_hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // Model state: list of pending destinations (0 = nothing), counter, sticky flag.
    int mq [DEPTH];
    int m_cnt;
    bit m_mis;
    int m_stalls;
    bit auto_wb;

    int vectors;
    int miscompares;
    int seen_stall;
    int seen_rs1;
    int seen_rs2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit pending(input int rs);
        if (rs == 0) return 1'b0;
        for (int k = 0; k < DEPTH; k++) if (mq[k] == rs) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < DEPTH; k++) mq[k] = 0;
        m_cnt = 0;
        m_mis = 1'b0;
    endfunction

    task automatic idle();
        bus.id_valid_i    = 1'b0;
        bus.id_rs1_addr_i = 5'd0;
        bus.id_rs1_used_i = 1'b0;
        bus.id_rs2_addr_i = 5'd0;
        bus.id_rs2_used_i = 1'b0;
        bus.id_rd_addr_i  = 5'd0;
        bus.id_rd_wren_i  = 1'b0;
        bus.hold_i        = 1'b0;
        bus.flush_i       = 1'b0;
        auto_wb           = 1'b1;
    endtask

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2,
                          input bit u2, input int rd, input bit we);
        bus.id_valid_i    = v;
        bus.id_rs1_addr_i = 5'(rs1);
        bus.id_rs1_used_i = u1;
        bus.id_rs2_addr_i = 5'(rs2);
        bus.id_rs2_used_i = u2;
        bus.id_rd_addr_i  = 5'(rd);
        bus.id_rd_wren_i  = we;
    endtask

    // One clock: check all outputs mid-cycle, then advance the model with the edge.
    task automatic cycle();
        bit e1, e2, es;
        int nvalid, expw;
        if (auto_wb) begin
            bus.wb_rd_wren_i = (mq[DEPTH-1] != 0);
            bus.wb_rd_addr_i = 5'(mq[DEPTH-1]);
        end
        #1;
        e1 = bus.id_valid_i && bus.id_rs1_used_i && pending(int'(bus.id_rs1_addr_i));
        e2 = bus.id_valid_i && bus.id_rs2_used_i && pending(int'(bus.id_rs2_addr_i));
        es = e1 || e2;
        nvalid = 0;
        for (int k = 0; k < DEPTH; k++) if (mq[k] != 0) nvalid++;
        check("stall_rs1", 32'(bus.stall_rs1_o), 32'(e1));
        check("stall_rs2", 32'(bus.stall_rs2_o), 32'(e2));
        check("stall", 32'(bus.stall_o), 32'(es));
        check("inflight", 32'(bus.inflight_o), 32'(nvalid));
        check("stall_cycles", 32'(bus.stall_cycles_o), 32'(m_cnt));
        check("wb_mismatch", 32'(bus.wb_mismatch_o), 32'(m_mis));
        if (bus.stall_o === 1'b1) seen_stall++;
        if (bus.stall_rs1_o === 1'b1) seen_rs1++;
        if (bus.stall_rs2_o === 1'b1) seen_rs2++;
        @(posedge clk_i);
        if (!bus.hold_i) begin
            expw = mq[DEPTH-1];
            if (expw != 0 && (!bus.wb_rd_wren_i || int'(bus.wb_rd_addr_i) != expw)) m_mis = 1'b1;
            if (bus.wb_rd_wren_i && bus.wb_rd_addr_i != 5'd0 && expw == 0) m_mis = 1'b1;
            if (es) begin
                m_stalls++;
                if (m_cnt < CMAX) m_cnt++;
            end
            for (int k = DEPTH - 1; k >= 1; k--) mq[k] = mq[k-1];
            mq[0] = (bus.id_valid_i && bus.id_rd_wren_i && bus.id_rd_addr_i != 5'd0
                     && !es && !bus.flush_i) ? int'(bus.id_rd_addr_i) : 0;
        end
        @(negedge clk_i);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2;
        rst_ni = 1'b0;
        model_clear();
        #1;
        check("rst_async_stall", 32'(bus.stall_o), 32'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_stalls    = 0;
        model_clear();
        idle();
        bus.wb_rd_wren_i = 1'b0;
        bus.wb_rd_addr_i = 5'd0;

        // Reset values
        @(negedge clk_i);
        @(negedge clk_i);
        check("reset_stall", 32'(bus.stall_o), 32'(0));
        check("reset_inflight", 32'(bus.inflight_o), 32'(0));
        check("reset_cycles", 32'(bus.stall_cycles_o), 32'(0));
        check("reset_mismatch", 32'(bus.wb_mismatch_o), 32'(0));
        rst_ni = 1'b1;

        // Producer x5, then a dependent rs1=x5 directly behind it
        set_id(1, 0, 0, 0, 0, 5, 1);
        cycle();
        set_id(1, 5, 1, 0, 0, 0, 0);
        seen_rs1 = 0;
        repeat (4) cycle();
        check("s1_rs1_len", 32'(seen_rs1), 32'(3));
        check("s1_cycles", 32'(bus.stall_cycles_o), 32'(3));
        check("s1_mismatch", 32'(bus.wb_mismatch_o), 32'(0));

        // Writes to x0 are never tracked
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1);
        cycle();
        set_id(1, 0, 1, 0, 1, 0, 0);
        seen_stall = 0;
        cycle();
        check("x0_stall", 32'(seen_stall), 32'(0));
        check("x0_inflight", 32'(bus.inflight_o), 32'(0));

        // Producer x7 in EX, dependent held for 4 cycles
        do_reset();
        set_id(1, 0, 0, 0, 0, 7, 1);
        cycle();
        set_id(1, 0, 0, 7, 1, 0, 0);
        seen_stall = 0;
        bus.hold_i = 1'b1;
        repeat (4) cycle();
        bus.hold_i = 1'b0;
        repeat (4) cycle();
        check("hold_stall_len", 32'(seen_stall), 32'(7));
        check("hold_cycles", 32'(bus.stall_cycles_o), 32'(3));

        // Flushed producer x9 never enters the shadow
        do_reset();
        set_id(1, 0, 0, 0, 0, 9, 1);
        bus.flush_i = 1'b1;
        cycle();
        bus.flush_i = 1'b0;
        set_id(1, 9, 1, 9, 1, 0, 0);
        seen_stall = 0;
        cycle();
        check("flush_stall", 32'(seen_stall), 32'(0));

        // x3 in MEM, both sources read x3
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1);
        cycle();
        idle();
        cycle();
        set_id(1, 3, 1, 3, 1, 0, 0);
        seen_rs1 = 0;
        seen_rs2 = 0;
        repeat (3) cycle();
        check("mem_rs1_len", 32'(seen_rs1), 32'(2));
        check("mem_rs2_len", 32'(seen_rs2), 32'(2));

        // Expected WB of x4 but x6 is written
        do_reset();
        set_id(1, 0, 0, 0, 0, 4, 1);
        cycle();
        idle();
        cycle();
        cycle();
        auto_wb = 1'b0;
        bus.wb_rd_wren_i = 1'b1;
        bus.wb_rd_addr_i = 5'd6;
        cycle();
        auto_wb = 1'b1;
        check("mis_set", 32'(bus.wb_mismatch_o), 32'(1));
        repeat (3) cycle();
        check("mis_sticky", 32'(bus.wb_mismatch_o), 32'(1));
        do_reset();
        check("mis_cleared", 32'(bus.wb_mismatch_o), 32'(0));

        // Reset in the middle of a stall drops stall_o at once
        set_id(1, 0, 0, 0, 0, 2, 1);
        cycle();
        set_id(1, 2, 1, 0, 0, 0, 0);
        cycle();
        do_reset();
        check("rst_mid_inflight", 32'(bus.inflight_o), 32'(0));

        // Counter saturates after 20 stall cycles
        do_reset();
        m_stalls = 0;
        set_id(1, 1, 1, 0, 0, 1, 1);
        for (int i = 0; i < 100 && m_stalls < 20; i++) cycle();
        check("sat_reached", 32'(m_stalls >= 20), 32'(1));
        check("sat_value", 32'(bus.stall_cycles_o), 32'(CMAX));

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_id(($urandom_range(0, 3) != 0), $urandom_range(0, 7), 1'($urandom),
                   $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom));
            bus.hold_i  = ($urandom_range(0, 7) == 0);
            bus.flush_i = ($urandom_range(0, 7) == 0);
            auto_wb     = ($urandom_range(0, 39) != 0);
            if (!auto_wb) begin
                bus.wb_rd_wren_i = 1'($urandom);
                bus.wb_rd_addr_i = 5'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
